// File: rtl/lane_pattern_scheduler_pkg.sv
// Shared encodings for the lane pattern scheduler: FSM states and sample values.
package lane_pattern_scheduler_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    SERVE = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic BIKE = 1'b1;
  localparam logic CAR  = 1'b0;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request at or after start_i, wrapping.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);
  logic [W:0]   sum;
  logic [W-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start_i} + (W+1)'(k);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      cand = sum[W-1:0];
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end
endmodule

// File: rtl/lane_pattern_scheduler.sv
// Time-shares one BBCBC detector across lane sensors in round-robin slots and
// credits detector hits to the lane that owned the detector.
module lane_pattern_scheduler
  import lane_pattern_scheduler_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int WINDOW    = 16,
  parameter int IDLE_TO   = 8,
  parameter int CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LANES-1:0]         lane_valid,
  input  logic [NUM_LANES-1:0]         lane_data,
  output logic [NUM_LANES-1:0]         lane_ready,
  input  logic                         clr_counts,
  output logic                         det_reset,
  output logic                         det_d_in,
  output logic                         det_valid_in,
  input  logic                         det_pattern_flag,
  output logic [$clog2(NUM_LANES)-1:0] active_lane,
  output logic                         busy,
  output logic [NUM_LANES*CNT_W-1:0]   hit_counts
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int SW = $clog2(WINDOW + 1);
  localparam int IW = $clog2(IDLE_TO + 1);

  state_e                            state_q, state_d;
  logic [LW-1:0]                     act_q, act_d, rr_q, rr_d;
  logic [SW-1:0]                     smp_q, smp_d;
  logic [IW-1:0]                     idl_q, idl_d;
  logic [NUM_LANES-1:0][CNT_W-1:0]   cnt_q;

  logic [LW-1:0] base, pick_start, pick_idx;
  logic          pick_found, xfer, credit;

  // IDLE scans after the rr pointer; DRAIN scans after the lane just served,
  // which becomes the rr pointer in the same cycle, so one finder serves both.
  assign base       = (state_q == IDLE) ? rr_q : act_q;
  assign pick_start = (base == LW'(NUM_LANES - 1)) ? '0 : base + 1'b1;

  rr_pick #(.N(NUM_LANES), .W(LW)) u_pick (
    .req_i   (lane_valid),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign xfer   = (state_q == SERVE) && lane_valid[act_q];
  assign credit = det_pattern_flag && ((state_q == SERVE) || (state_q == DRAIN));

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    rr_d    = rr_q;
    smp_d   = smp_q;
    idl_d   = idl_q;
    case (state_q)
      IDLE: if (pick_found) begin
        act_d   = pick_idx;
        state_d = FLUSH;
      end
      FLUSH: begin
        smp_d   = '0;
        idl_d   = '0;
        state_d = SERVE;
      end
      SERVE: if (xfer) begin
        smp_d = smp_q + 1'b1;
        idl_d = '0;
        if (smp_q == SW'(WINDOW - 1)) state_d = DRAIN;
      end else begin
        idl_d = idl_q + 1'b1;
        if (idl_q == IW'(IDLE_TO - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        rr_d = act_q;
        if (pick_found) begin
          act_d   = pick_idx;
          state_d = FLUSH;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      act_q   <= '0;
      rr_q    <= LW'(NUM_LANES - 1);
      smp_q   <= '0;
      idl_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      rr_q    <= rr_d;
      smp_q   <= smp_d;
      idl_q   <= idl_d;
    end
  end

  // Clear has priority over a coincident credit; counts stick at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_counts) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (credit && (act_q == LW'(i)) && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  assign det_reset    = (state_q == IDLE) || (state_q == FLUSH);
  assign busy         = (state_q != IDLE);
  assign lane_ready   = (state_q == SERVE) ? ({{(NUM_LANES-1){1'b0}}, 1'b1} << act_q) : '0;
  assign det_valid_in = xfer;
  assign det_d_in     = (state_q == SERVE) ? lane_data[act_q] : CAR;
  assign active_lane  = act_q;
  assign hit_counts   = cnt_q;
endmodule

// File: tb/tb_lane_pattern_scheduler.sv
// Bench for lane_pattern_scheduler: behavioural BBCBC detector, slot-level model,
// per-cycle output compare and directed scenarios with literal expectations.
module tb_lane_pattern_scheduler;
  localparam int N = 4, WIN = 16, ITO = 8;

  logic         clk = 1'b0, reset = 1'b1;
  logic [N-1:0] lane_valid = '0, lane_data = '0;
  logic         clr_counts = 1'b0;
  logic         det_flag = 1'b0;

  logic [N-1:0] lane_ready, lane_ready2;
  logic         det_reset, det_d_in, det_valid_in, busy;
  logic         det_reset2, det_d_in2, det_valid_in2, busy2;
  logic [1:0]   active_lane, active_lane2;
  logic [31:0]  hit_counts;
  logic [7:0]   hit_counts2;

  lane_pattern_scheduler #(.NUM_LANES(N), .WINDOW(WIN), .IDLE_TO(ITO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .lane_valid(lane_valid), .lane_data(lane_data),
    .lane_ready(lane_ready), .clr_counts(clr_counts), .det_reset(det_reset),
    .det_d_in(det_d_in), .det_valid_in(det_valid_in), .det_pattern_flag(det_flag),
    .active_lane(active_lane), .busy(busy), .hit_counts(hit_counts));

  lane_pattern_scheduler #(.NUM_LANES(N), .WINDOW(WIN), .IDLE_TO(ITO), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .lane_valid(lane_valid), .lane_data(lane_data),
    .lane_ready(lane_ready2), .clr_counts(clr_counts), .det_reset(det_reset2),
    .det_d_in(det_d_in2), .det_valid_in(det_valid_in2), .det_pattern_flag(det_flag),
    .active_lane(active_lane2), .busy(busy2), .hit_counts(hit_counts2));

  always #5 clk = ~clk;

  // Detector: flags 1,1,0,1,0 one cycle after the completing sample.
  logic [4:0] hist = '0;
  int         seen = 0;
  always @(posedge clk) begin
    if (det_reset) begin
      hist <= '0; seen <= 0; det_flag <= 1'b0;
    end else begin
      det_flag <= det_valid_in && (seen >= 4) && ({hist[3:0], det_d_in} == 5'b11010);
      if (det_valid_in) begin
        hist <= {hist[3:0], det_d_in};
        seen <= (seen < 5) ? seen + 1 : 5;
      end
    end
  end

  int checks = 0, failures = 0;
  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // Slot-level model: phase 0 idle, 1 flush, 2 serve, 3 drain.
  int m_ph = 0, m_lane = 0, m_rr = N - 1, m_smp = 0, m_idl = 0;
  int m_c8[N], m_c2[N];

  function automatic int next_req(int from, logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph = 0; m_lane = 0; m_rr = N - 1; m_smp = 0; m_idl = 0;
      for (int i = 0; i < N; i++) begin m_c8[i] = 0; m_c2[i] = 0; end
    end else begin
      int j;
      bit cr;
      cr = det_flag && (m_ph >= 2);
      for (int i = 0; i < N; i++)
        if (clr_counts) begin m_c8[i] = 0; m_c2[i] = 0; end
        else if (cr && i == m_lane) begin
          if (m_c8[i] < 255) m_c8[i]++;
          if (m_c2[i] < 3) m_c2[i]++;
        end
      case (m_ph)
        0: begin j = next_req(m_rr, lane_valid); if (j >= 0) begin m_lane = j; m_ph = 1; end end
        1: begin m_smp = 0; m_idl = 0; m_ph = 2; end
        2: if (lane_valid[m_lane]) begin
             m_smp++; m_idl = 0; if (m_smp == WIN) m_ph = 3;
           end else begin
             m_idl++; if (m_idl == ITO) m_ph = 3;
           end
        default: begin
          m_rr = m_lane; j = next_req(m_lane, lane_valid);
          if (j >= 0) begin m_lane = j; m_ph = 1; end else m_ph = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [31:0] p8;
    logic [7:0]  p2;
    logic [N-1:0] er;
    for (int i = 0; i < N; i++) begin p8[i*8 +: 8] = 8'(m_c8[i]); p2[i*2 +: 2] = 2'(m_c2[i]); end
    er = (m_ph == 2) ? (N'(1) << m_lane) : '0;
    chk("busy", busy, m_ph != 0);
    chk("det_reset", det_reset, m_ph <= 1);
    chk("lane_ready", lane_ready, er);
    chk("det_valid_in", det_valid_in, (m_ph == 2) && lane_valid[m_lane]);
    chk("det_d_in", det_d_in, (m_ph == 2) && lane_data[m_lane]);
    chk("active_lane", active_lane, m_lane);
    chk("hit_counts", hit_counts, p8);
    chk("hit_counts_w2", hit_counts2, p2);
    chk("busy_w2", busy2, m_ph != 0);
  end

  // Round-robin monitor: grant order and transfers per slot.
  bit rr_mon = 0;
  int grants[$], slots[$], cur = 0;
  always @(negedge clk) if (rr_mon) begin
    if (busy && det_reset) begin
      if (grants.size() > 0) slots.push_back(cur);
      grants.push_back(int'(active_lane));
      cur = 0;
    end else if (|(lane_ready & lane_valid)) cur++;
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic send_seq(int ln, int n, logic [31:0] bits);
    for (int k = 0; k < n; k++) begin
      int b;
      b = 0;
      lane_valid[ln] = 1'b1; lane_data[ln] = bits[k];
      @(negedge clk);
      while (!lane_ready[ln] && b < 100) begin @(negedge clk); b++; end
      chk("send_timeout", b >= 100, 0);
      tick();
    end
    lane_valid[ln] = 1'b0; lane_data[ln] = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    @(negedge clk);
    while (busy && b < 200) begin @(negedge clk); b++; end
    chk("idle_timeout", b >= 200, 0);
    tick();
  endtask

  initial begin
    int b, cnt;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_det_reset", det_reset, 1);
    chk("rst_ready", lane_ready, 0); chk("rst_counts", hit_counts, 0);
    tick(); reset = 1'b1; tick();

    // single hit on lane 0
    send_seq(0, 5, 32'hB); wait_idle();
    chk("single_hit", hit_counts, 32'h1); chk("single_hit_w2", hit_counts2, 8'h1);

    // reset mid-SERVE after lane 1 scores a hit
    send_seq(1, 5, 32'hB); tick();
    chk("pre_rst_counts", hit_counts, 32'h101); chk("pre_rst_busy", busy, 1);
    reset = 1'b0; #1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_det_reset", det_reset, 1);
    chk("mid_rst_ready", lane_ready, 0); chk("mid_rst_counts", hit_counts, 0);
    tick(); reset = 1'b1; tick();

    // round robin over lanes 0,2,3
    rr_mon = 1; lane_valid = 4'b1101; lane_data = '0; b = 0;
    while (grants.size() < 4 && b < 300) begin tick(); b++; end
    lane_valid = '0; rr_mon = 0;
    chk("rr_timeout", b >= 300, 0);
    if (grants.size() >= 4) begin
      chk("rr_grant0", grants[0], 0); chk("rr_grant1", grants[1], 2);
      chk("rr_grant2", grants[2], 3); chk("rr_grant3", grants[3], 0);
      chk("rr_slot0", slots[0], 16); chk("rr_slot1", slots[1], 16); chk("rr_slot2", slots[2], 16);
    end
    wait_idle();

    // idle timeout on lane 3
    send_seq(3, 3, 32'h3);
    cnt = 0; b = 0;
    @(negedge clk);
    while (lane_ready != 0 && b < 30) begin cnt++; @(negedge clk); b++; end
    chk("idle_cycles", cnt, 8);
    chk("drain_busy", busy, 1); chk("drain_det_reset", det_reset, 0);
    @(negedge clk);
    chk("after_drain_idle", busy, 0);
    tick();

    // pattern split across two slots of lane 0
    send_seq(0, 17, 32'h0000B000); wait_idle();
    chk("split_no_hit", hit_counts, 0);

    // saturation with the 2-bit instance
    clr_counts = 1'b1; tick(); clr_counts = 1'b0;
    chk("clr_counts", hit_counts, 0);
    repeat (5) begin send_seq(2, 5, 32'hB); wait_idle(); end
    chk("sat_w2", hit_counts2[5:4], 2'd3); chk("sat_w8", hit_counts[23:16], 8'd5);

    // clear coincident with a credit
    send_seq(2, 5, 32'hB);
    chk("flag_pre_clr", det_flag, 1);
    clr_counts = 1'b1; tick(); clr_counts = 1'b0;
    chk("clr_wins_w8", hit_counts, 0); chk("clr_wins_w2", hit_counts2, 0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lane_pattern_scheduler.md
Name: lane_pattern_scheduler

Overview:
- Time-shares one vehicle pattern detector (BBCBC on a bike=1/car=0 sample stream) between NUM_LANES lane sensors.
- Grants lanes round-robin in slots of up to WINDOW accepted samples and flushes the detector between slots.
- Credits each detector hit to the lane being served and keeps a saturating hit counter per lane.
- Sits between the lane sensor front-ends and the detector instance.

Parameters:
- NUM_LANES, 4, number of requesting lanes (2..8).
- WINDOW, 16, maximum accepted samples per slot.
- IDLE_TO, 8, consecutive SERVE cycles without a valid sample that end a slot early.
- CNT_W, 8, width of each per-lane hit counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- lane_valid  in  NUM_LANES  per-lane sample valid
- lane_data  in  NUM_LANES  per-lane sample, 1=bike, 0=car
- lane_ready  out  NUM_LANES  per-lane accept; a sample transfers when valid and ready are both high
- clr_counts  in  1  synchronous clear of all hit counters
- det_reset  out  1  synchronous active-high reset to the detector
- det_d_in  out  1  sample to the detector
- det_valid_in  out  1  valid to the detector
- det_pattern_flag  in  1  detector hit pulse; registered, so it appears one cycle after the completing sample
- active_lane  out  $clog2(NUM_LANES)  lane currently owning the detector
- busy  out  1  high when state is not IDLE
- hit_counts  out  NUM_LANES*CNT_W  lane i counter in bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset asserted (reset=0), taking effect immediately:
  - state=IDLE, all counters 0, active_lane=0, rr pointer=NUM_LANES-1.
  - det_reset=1, det_valid_in=0, det_d_in=0, lane_ready=0, busy=0.
- States:
  - IDLE:
    - Scan lanes starting at rr pointer+1, wrapping, for the first lane with lane_valid=1.
    - If one is found, latch it into active_lane and go to FLUSH. Otherwise stay in IDLE.
    - det_reset=1 throughout IDLE.
  - FLUSH (1 cycle):
    - det_reset=1, lane_ready=0.
    - Clear the sample counter and the idle counter, then go to SERVE.
  - SERVE:
    - det_reset=0.
    - lane_ready[active_lane]=1; every other bit of lane_ready is 0.
    - det_valid_in=lane_valid[active_lane], det_d_in=lane_data[active_lane], both combinational.
    - Each transfer increments the sample counter and clears the idle counter. A cycle without a transfer increments the idle counter.
    - Go to DRAIN after the transfer that makes the sample count WINDOW, or when the idle count reaches IDLE_TO.
  - DRAIN (1 cycle):
    - det_valid_in=0, lane_ready=0.
    - Captures the hit pulse from the last sample.
    - rr pointer := active_lane.
    - Next state: FLUSH for the next requesting lane after active_lane (wrapping, and active_lane itself counts as last candidate), or IDLE if no lane is requesting.
- Hit crediting:
  - det_pattern_flag=1 in SERVE or DRAIN increments hit_counts[active_lane].
  - The flag is ignored in IDLE and FLUSH.
  - Counters saturate at 2^CNT_W-1.
- clr_counts=1 zeroes all counters. If a credit lands in the same cycle, clear wins.
- Detector pattern state never carries between slots: a pattern split across two slots is not counted.
- Latency: lane_valid rise in IDLE -> FLUSH next cycle -> first transfer possible 2 cycles after the rise.
- With a single requester, that lane is re-granted after DRAIN, with FLUSH in between.
- No combinational path from det_pattern_flag to any output.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'd0, FLUSH=2'd1, SERVE=2'd2, DRAIN=2'd3;
  - sample constants BIKE=1'b1 and CAR=1'b0.
- Sub-module rr_pick: combinational round-robin finder. Inputs are the request vector and start index; outputs are found and index. It is used in IDLE and DRAIN.

Test Plan:
- Reset mid-SERVE:
  - Stimulus: lane 1 has sent 5 samples, then reset=0 for 1 cycle.
  - Response: busy=0 and det_reset=1 immediately; all counters 0; lane_ready=0.
- Single hit:
  - Stimulus: lane 0 feeds 1,1,0,1,0 back-to-back.
  - Response: det_pattern_flag pulses one cycle after the final 0; hit_counts[0]=1, other counters 0.
- Round-robin:
  - Stimulus: lanes 0, 2 and 3 valid continuously with WINDOW=16.
  - Response: grant order 0,2,3,0. Each slot is exactly 16 transfers, followed by 1 DRAIN cycle and 1 FLUSH cycle.
- Idle timeout:
  - Stimulus: lane 3 sends 3 samples, then drops valid.
  - Response: DRAIN after 8 idle cycles; then IDLE, busy=0.
- Split pattern:
  - Stimulus: lane 0 ends a slot with 1,1,0,1; its next slot begins with 0.
  - Response: no hit credited.
- Saturation and clear:
  - Stimulus: CNT_W=2; 5 hits on lane 2.
  - Response: count=3. clr_counts asserted in the same cycle as a hit gives count=0.
